// File: rtl/aim65_bus_pkg.sv
// Shared types and default AIM65 memory map for the bus matrix.
package aim65_bus_pkg;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} wait_state_t;

    localparam int unsigned SEL_W       = 5;
    localparam logic [SEL_W-1:0] SEL_NONE    = 5'd31;
    localparam logic [SEL_W-1:0] SEL_BANKREG = 5'd30;

    // Region 0 occupies the least-significant slice.
    localparam logic [11*16-1:0] DEF_BASE = {
        16'hAC00, 16'hA800, 16'hA400, 16'hA000, 16'hB000, 16'hC000,
        16'hD000, 16'hE000, 16'hF000, 16'h9000, 16'h0000};
    localparam logic [11*16-1:0] DEF_MASK = {
        16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hF000, 16'hF000,
        16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'h8000};
    localparam logic [11*4-1:0]  DEF_WAIT = '0;

endpackage

// File: rtl/aim65_waitgen.sv
// Wait-state generator: stretches an access by wait_n cycles via rdy.
module aim65_waitgen
    import aim65_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] wait_n,
    input  logic       hold,
    output logic       rdy,
    output logic       in_wait
);

    wait_state_t state;
    logic [3:0]  cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && wait_n != 4'd0) begin
                        state <= WAIT;
                        cnt   <= wait_n - 4'd1;
                    end
                end
                WAIT: begin
                    // hold only freezes the countdown; a zero count always completes
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else if (!hold) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdy     = ~(((state == IDLE) && start && (wait_n != 4'd0)) ||
                       ((state == WAIT) && (cnt != 4'd0)));
    assign in_wait = (state == WAIT);

endmodule

// File: rtl/aim65_busmatrix.sv
// AIM65 address decoder, wait-state inserter and CPU read-data matrix.
// Optional open-bus read hold enabled by AIM65_BUSMATRIX_OPENBUS_EN.
module aim65_busmatrix
    import aim65_bus_pkg::*;
#(
    parameter int unsigned NUM_REGIONS   = 11,
    parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = DEF_BASE,
    parameter logic [NUM_REGIONS*16-1:0] REGION_MASK = DEF_MASK,
    parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT = DEF_WAIT,
    parameter int unsigned BANK_REGION_A = 5,
    parameter int unsigned BANK_REGION_B = 6,
    parameter int unsigned NUM_BANKS     = 3,
    parameter int unsigned BANK_W        = 2,
    parameter logic [BANK_W-1:0] BANK_RESET    = 1,
    parameter logic [15:0]       BANK_REG_ADDR = 16'h8FF0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [15:0]              addr,
    input  logic                     cpu_vma,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_di,
    input  logic [NUM_REGIONS*8-1:0] dev_do,
    input  logic [NUM_BANKS*8-1:0]   bank_a_do,
    input  logic [NUM_BANKS*8-1:0]   bank_b_do,
    output logic [NUM_REGIONS-1:0]   cs,
    output logic [7:0]               cpu_data,
    output logic                     cpu_rdy,
    output logic [BANK_W-1:0]        bank_sel,
    output logic                     decode_miss
);

    logic             vma_ok;
    logic             bankreg_hit;
    logic             found;
    int unsigned      hit_idx;
    logic [3:0]       hit_wait;
    logic [SEL_W-1:0] sel_q;
    logic             in_wait;
    logic [7:0]       rd_data;
    logic             unused_di;

    // The CPU strobe is meaningless while reset is held.
    assign vma_ok      = cpu_vma & reset_n;
    assign bankreg_hit = (addr == BANK_REG_ADDR);
    assign unused_di   = &{1'b0, cpu_di[7:BANK_W]};

    // Priority decode: lowest matching index wins.
    always_comb begin
        found    = 1'b0;
        hit_idx  = 0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*16 +: 16]) == REGION_BASE[i*16 +: 16]) begin
                found   = 1'b1;
                hit_idx = i;
            end
        end
        hit_wait = REGION_WAIT[hit_idx*4 +: 4];
    end

    // During a stall the select follows the latched region, not addr.
    always_comb begin
        cs = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (in_wait)
                cs[i] = (sel_q == SEL_W'(i));
            else
                cs[i] = vma_ok && found && !bankreg_hit && (hit_idx == i);
        end
    end

    aim65_waitgen u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (vma_ok && !in_wait && found && !bankreg_hit),
        .wait_n  (hit_wait),
        .hold    (~vma_ok),
        .rdy     (cpu_rdy),
        .in_wait (in_wait)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q       <= SEL_NONE;
            bank_sel    <= BANK_RESET;
            decode_miss <= 1'b0;
        end else begin
            decode_miss <= vma_ok && !in_wait && !found && !bankreg_hit;
            if (vma_ok && !in_wait) begin
                if (bankreg_hit)
                    sel_q <= SEL_BANKREG;
                else if (found)
                    sel_q <= SEL_W'(hit_idx);
                else
                    sel_q <= SEL_NONE;
            end
            if (vma_ok && cpu_we && bankreg_hit)
                bank_sel <= cpu_di[BANK_W-1:0];
        end
    end

`ifdef AIM65_BUSMATRIX_OPENBUS_EN
    logic [7:0] last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_q <= 8'h00;
        else if (sel_q != SEL_NONE)
            last_q <= rd_data;
    end
`endif

    always_comb begin
        rd_data = 8'h00;
        if (sel_q == SEL_BANKREG) begin
            rd_data = 8'(bank_sel);
        end else if (sel_q == SEL_NONE) begin
`ifdef AIM65_BUSMATRIX_OPENBUS_EN
            rd_data = last_q;
`else
            rd_data = 8'h00;
`endif
        end else if (sel_q == SEL_W'(BANK_REGION_A) || sel_q == SEL_W'(BANK_REGION_B)) begin
            // Bank 0 and out-of-range banks read as an empty socket.
            if (bank_sel != '0 && int'(bank_sel) <= int'(NUM_BANKS)) begin
                if (sel_q == SEL_W'(BANK_REGION_A))
                    rd_data = bank_a_do[(int'(bank_sel) - 1)*8 +: 8];
                else
                    rd_data = bank_b_do[(int'(bank_sel) - 1)*8 +: 8];
            end
        end else if (int'(sel_q) < int'(NUM_REGIONS)) begin
            rd_data = dev_do[int'(sel_q)*8 +: 8];
        end
    end

    assign cpu_data = rd_data;

endmodule

// File: tb/tb_aim65_busmatrix.sv
// Directed scoreboard bench for aim65_busmatrix (region 2 built with 3 wait states).
module tb_aim65_busmatrix;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        cpu_vma;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic [87:0] dev_do;
    logic [23:0] bank_a_do;
    logic [23:0] bank_b_do;
    logic [10:0] cs;
    logic [7:0]  cpu_data;
    logic        cpu_rdy;
    logic [1:0]  bank_sel;
    logic        decode_miss;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    aim65_busmatrix #(
        .REGION_WAIT (44'h00000000300)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .cpu_vma     (cpu_vma),
        .cpu_we      (cpu_we),
        .cpu_di      (cpu_di),
        .dev_do      (dev_do),
        .bank_a_do   (bank_a_do),
        .bank_b_do   (bank_b_do),
        .cs          (cs),
        .cpu_data    (cpu_data),
        .cpu_rdy     (cpu_rdy),
        .bank_sel    (bank_sel),
        .decode_miss (decode_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(cpu_data), 32'(e));
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic v, input logic w, input logic [7:0] d);
        @(negedge clk);
        addr    = a;
        cpu_vma = v;
        cpu_we  = w;
        cpu_di  = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        addr      = 16'h1234;
        cpu_vma   = 1'b1;
        cpu_we    = 1'b0;
        cpu_di    = 8'h00;
        dev_do    = '0;
        dev_do[0*8 +: 8] = 8'hA5;
        dev_do[1*8 +: 8] = 8'h5A;
        dev_do[2*8 +: 8] = 8'h77;
        dev_do[5*8 +: 8] = 8'hEE;
        bank_a_do = {8'h33, 8'h3C, 8'h11};
        bank_b_do = {8'h66, 8'h55, 8'h44};
        tick();
        tick();
        chk("rst_cs", 32'(cs), 32'h0);
        chk("rst_rdy", 32'(cpu_rdy), 32'h1);
        chk("rst_data", 32'(cpu_data), 32'h00);
        chk("rst_bank", 32'(bank_sel), 32'h1);
        chk("rst_miss", 32'(decode_miss), 32'h0);
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;

        // Zero-wait read of region 0
        drive(16'h1234, 1'b1, 1'b0, 8'h00);
        chk("r0_cs", 32'(cs), 32'h001);
        chk("r0_rdy_t0", 32'(cpu_rdy), 32'h1);
        exp_q.push_back(8'hA5);
        tick();
        chk_pop("r0_data");
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        exp_q.push_back(8'hA5);
        tick();
        chk_pop("r0_data_hold");

        // Three-wait read of region 2
        drive(16'hF000, 1'b1, 1'b0, 8'h00);
        chk("w3_cs", 32'(cs), 32'h004);
        chk("w3_rdy_t0", 32'(cpu_rdy), 32'h0);
        exp_q.push_back(8'h77);
        tick();
        chk_pop("w3_data_t1");
        chk("w3_rdy_t1", 32'(cpu_rdy), 32'h0);
        tick();
        chk("w3_rdy_t2", 32'(cpu_rdy), 32'h0);
        chk("w3_cs_t2", 32'(cs), 32'h004);
        tick();
        chk("w3_rdy_t3", 32'(cpu_rdy), 32'h1);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 8'h00);

        // Bank write, banked read and bank readback
        drive(16'h8FF0, 1'b1, 1'b1, 8'h02);
        chk("bw_cs", 32'(cs), 32'h0);
        tick();
        chk("bw_bank", 32'(bank_sel), 32'h2);
        chk("bw_miss", 32'(decode_miss), 32'h0);
        drive(16'hC000, 1'b1, 1'b0, 8'h00);
        chk("ba_cs", 32'(cs), 32'h020);
        exp_q.push_back(8'h3C);
        tick();
        chk_pop("ba_data");
        drive(16'h8FF0, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h02);
        tick();
        chk_pop("breg_rd");
        drive(16'h8FF0, 1'b1, 1'b1, 8'h03);
        exp_q.push_back(8'h03);
        tick();
        chk_pop("breg_wr_rd");
        drive(16'hB000, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h66);
        tick();
        chk_pop("bb_bank3");

        // Bank 0 is an empty socket; other-address writes leave bank alone
        drive(16'h8FF0, 1'b1, 1'b1, 8'h00);
        tick();
        drive(16'hB000, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h00);
        tick();
        chk_pop("bb_empty");
        drive(16'h1234, 1'b1, 1'b1, 8'h03);
        tick();
        chk("bank_other_wr", 32'(bank_sel), 32'h0);
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("bank_rst", 32'(bank_sel), 32'h1);
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;

        // Unmapped access after a region read
        drive(16'h9000, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'h5A);
        tick();
        chk_pop("r1_data");
        drive(16'h8123, 1'b1, 1'b0, 8'h00);
        chk("miss_cs", 32'(cs), 32'h0);
`ifdef AIM65_BUSMATRIX_OPENBUS_EN
        exp_q.push_back(8'h5A);
`else
        exp_q.push_back(8'h00);
`endif
        tick();
        chk("miss_pulse", 32'(decode_miss), 32'h1);
        chk_pop("miss_data");
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        tick();
        chk("miss_clear", 32'(decode_miss), 32'h0);

        // Reset in the second wait cycle of a three-wait access
        drive(16'hF000, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        chk("abort_pre_rdy", 32'(cpu_rdy), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_rdy", 32'(cpu_rdy), 32'h1);
        chk("abort_cs", 32'(cs), 32'h0);
        drive(16'h0000, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        chk_pop("abort_data");
        chk("abort_idle_rdy", 32'(cpu_rdy), 32'h1);
        drive(16'h1234, 1'b1, 1'b0, 8'h00);
        chk("abort_idle_cs", 32'(cs), 32'h001);
        chk("abort_idle_rdy2", 32'(cpu_rdy), 32'h1);
        tick();
        drive(16'h0000, 1'b0, 1'b0, 8'h00);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aim65_busmatrix.md
# aim65_busmatrix

Parametrised AIM65 address decoder and CPU read-data matrix; successor to the fixed-map decoder/mux. Decodes the 6502 address bus against a parameter-defined region table and drives one-hot chip selects. Inserts per-region wait states on `cpu_rdy`, steers registered read data back to the CPU, and holds a CPU-writable ROM bank register that selects the image shown in two banked sockets. Sits between the CPU core and every memory and peripheral block.

## Interface
- `NUM_REGIONS`, 11: number of decoded regions; index 0 has the highest priority.
- `REGION_BASE`, AIM65 map: flat `NUM_REGIONS*16` vector; default bases are 0000, 9000, F000, E000, D000, C000, B000, A000, A400, A800, AC00.
- `REGION_MASK`, AIM65 map: flat `NUM_REGIONS*16` vector; a region hits when `(addr & mask) == base`; default masks are 8000, F000×6, FF00×4.
- `REGION_WAIT`, all 0: flat `NUM_REGIONS*4` vector of wait states per region (0–15).
- `BANK_REGION_A`, 5: index of the first banked region (C000 socket).
- `BANK_REGION_B`, 6: index of the second banked region (B000 socket).
- `NUM_BANKS`, 3: number of ROM images per banked socket.
- `BANK_W`, 2: width of the bank register.
- `BANK_RESET`, 1: reset value of the bank register.
- `BANK_REG_ADDR`, 16'h8FF0: address of the bank register.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `addr`  in  16  CPU address.
- `cpu_vma`  in  1  valid bus cycle.
- `cpu_we`  in  1  write strobe.
- `cpu_di`  in  8  CPU write data.
- `dev_do`  in  `NUM_REGIONS*8`  per-region read data; slice i belongs to region i. Slices for the banked regions are ignored.
- `bank_a_do`  in  `NUM_BANKS*8`  image data for banks 1..`NUM_BANKS`, socket A.
- `bank_b_do`  in  `NUM_BANKS*8`  image data for banks 1..`NUM_BANKS`, socket B.
- `cs`  out  `NUM_REGIONS`  one-hot chip selects.
- `cpu_data`  out  8  read data to the CPU.
- `cpu_rdy`  out  1  low stalls the CPU.
- `bank_sel`  out  `BANK_W`  current bank.
- `decode_miss`  out  1  one-cycle pulse on an access to an unmapped address.

## Operation
- **Chip select:**
  - `cs[i]` is combinational: `cpu_vma` AND region i hits AND no lower index hits.
  - A `BANK_REG_ADDR` match suppresses all `cs`.
- **Select register:**
  - Each `clk` edge with `cpu_vma` registers `sel_q` as one of: the hit index, BANKREG, or NONE.
  - Without `cpu_vma`, `sel_q` holds its value.
- **Read mux on `sel_q`:**
  - Ordinary region i: `dev_do` slice i.
  - BANKREG: `bank_sel` zero-extended to 8 bits.
  - Banked region with `bank_sel` = 0 or greater than `NUM_BANKS`: 8'h00 (empty socket).
  - Banked region with any other `bank_sel`: slice `bank_sel-1` of the matching `bank_*_do` input.
  - NONE: see Configuration.
- **Bank register:**
  - Loads `cpu_di[BANK_W-1:0]` on a clock edge with `cpu_vma & cpu_we & addr==BANK_REG_ADDR`.
  - Writes to any other address never change it.
- **Wait FSM:** states IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE, with `cpu_vma` and the hit region's wait W greater than 0: go to WAIT and load `cnt` = W-1.
  - WAIT with `cnt` ≠ 0: decrement `cnt`.
  - WAIT with `cnt` = 0: this is the completion cycle; return to IDLE.
  - `cpu_rdy` = NOT((IDLE & `cpu_vma` & W>0) OR (WAIT & `cnt`≠0)).
  - The CPU holds `addr` and `cpu_vma` while `cpu_rdy` is low.
  - In WAIT, `addr` is ignored for decode; `cs` stays on the latched region.
- **`decode_miss`:** registered; pulses for one cycle after a `cpu_vma` cycle with no hit and no bank register match.

## Timing
- Access to a region with W wait states:
  - `cs` rises in T0.
  - `cpu_rdy` is low for cycles T0..T(W-1) and high in TW.
  - `cpu_data` is valid from T1 and stays valid until the next `cpu_vma` edge.
  - With W = 0, `cpu_rdy` stays high throughout.
- A bank write at edge E changes `bank_sel` after E. A read of a banked socket in the cycle after E returns the new image.
- Simultaneous bank register write and read: the write takes effect and the readback in the next cycle shows the new value.
- Reset values:
  - `cs` = 0 (`cpu_vma` is ignored while in reset).
  - `cpu_data` = 8'h00, `cpu_rdy` = 1, `bank_sel` = `BANK_RESET`, `decode_miss` = 0.
  - State = IDLE, `sel_q` = NONE, `cnt` = 0.
- Reset asserted mid-WAIT aborts the access immediately and releases `cpu_rdy`.

## Configuration
- `AIM65_BUSMATRIX_OPENBUS_EN`:
  - Defined: reads with `sel_q` = NONE return the last valid `cpu_data` value, held in an 8-bit register that resets to 8'h00 (6502 open-bus behaviour).
  - Undefined: reads with `sel_q` = NONE return 8'h00 and the hold register is not built.

## Structure
- Package `aim65_bus_pkg` holds:
  - the FSM state enum (IDLE, WAIT);
  - the `sel_q` encoding constants NONE and BANKREG;
  - the default AIM65 map constants used for `REGION_BASE`, `REGION_MASK` and `REGION_WAIT`.
- Sub-module `aim65_waitgen` contains the IDLE/WAIT FSM and counter. It takes `start`, `wait_n[3:0]` and `hold`, and produces `rdy`.

## Test plan
- Read 16'h1234 with `dev_do[0]` = 8'hA5 and defaults → `cs[0]` = 1 in T0, `cpu_data` = 8'hA5 in T1, `cpu_rdy` stays high.
- `REGION_WAIT` for region 2 = 3; read F000 → `cpu_rdy` low for 3 cycles, high in the 4th; `cpu_data` = `dev_do[2]` from T1.
- Write 8'h02 to 8FF0, then read C000 with `bank_a_do` slice 1 = 8'h3C → 8'h3C; read 8FF0 → 8'h02.
- Write 8'h00 to 8FF0, read B000 → 8'h00; assert `reset_n` low → `bank_sel` = 1.
- Read 8123 (unmapped) after reading 8'h5A → `decode_miss` pulses; `cpu_data` = 8'h5A with `AIM65_BUSMATRIX_OPENBUS_EN` defined, 8'h00 without.
- Assert reset in the 2nd WAIT cycle of a 3-wait access → `cpu_rdy` = 1 immediately; after release, the state is IDLE and `cpu_data` = 8'h00.
